// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if
//
// Purpose: groups the three handshake/bus paths of the multi-byte add
// sequencer into one bundle:
//   - the byte-serial operand input stream
//   - the 8-bit adder core connection
//   - the byte-serial result output stream
//
// Signals:
//   in_valid, in_byte, in_cin   operand stream from upstream
//   in_ready                    sequencer accepts an operand byte
//   op_sub                      subtract select (only when SUBTRACT_EN is defined)
//   add_a, add_b, add_cin       operands driven to the adder core
//   add_sum, add_cout           adder core results (combinational)
//   out_valid, out_byte,
//   out_last, out_carry         result stream to downstream
//   out_ready                   downstream accepts a result byte
//
// Modports:
//   master  sequencer side
//   slave   environment side (upstream, adder core, downstream)
//
// Optional feature macro: SUBTRACT_EN
interface add_seq_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       in_cin;
`ifdef SUBTRACT_EN
  logic       op_sub;
`endif
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_last;
  logic       out_carry;

  modport master (
`ifdef SUBTRACT_EN
    input  op_sub,
`endif
    input  in_valid, in_byte, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin,
    output out_valid, out_byte, out_last, out_carry
  );

  modport slave (
`ifdef SUBTRACT_EN
    output op_sub,
`endif
    output in_valid, in_byte, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin,
    input  out_valid, out_byte, out_last, out_carry
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl
//
// Purpose: multi-byte add sequencer wrapped around an external 8-bit adder
// core.
//   1. Collects two NBYTES-wide operands byte-serially, LSB first:
//      A[0..NBYTES-1], then B[0..NBYTES-1].
//   2. Drives them through the adder one byte per cycle, chaining the carry
//      in a register.
//   3. Streams the result bytes and the final carry out.
//
// Parameters:
//   NBYTES  operand width in bytes (2..16), default 4
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   add_seq_ctrl_if.master
//         (operand stream, adder core connection, result stream)
//   busy  high while adding or draining results
//
// Optional feature macro: SUBTRACT_EN
//   When defined, op_sub (sampled with A[0]) selects A-B:
//     - the B bytes are inverted;
//     - the first carry is forced to 1.
//   out_carry=1 then means "no borrow".
module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic           clk,
  input  logic           rst,
  add_seq_ctrl_if.master bus,
  output logic           busy
);

  localparam int CW = $clog2(2 * NBYTES);
  localparam int IW = $clog2(NBYTES);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_ADD   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CW-1:0] LAST_IN   = CW'(2 * NBYTES - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [CW-1:0] NB_CW     = CW'(NBYTES);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          cin_lat;
  logic          sub_mode;

  logic [7:0] op_a [NBYTES];
  logic [7:0] op_b [NBYTES];
  logic [7:0] res  [NBYTES];

  logic [IW-1:0] byte_idx;
  logic [IW-1:0] load_idx;
  logic          in_fire;
  logic          out_fire;
  logic          last_byte;

  // During LOAD, cnt spans both operands; fold it back to a per-operand index.
  assign byte_idx  = cnt[IW-1:0];
  assign load_idx  = (cnt < NB_CW) ? cnt[IW-1:0] : IW'(cnt - NB_CW);
  assign last_byte = (cnt == LAST_BYTE);
  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;

`ifdef SUBTRACT_EN
  logic sub_lat;
  assign sub_mode = sub_lat;
`else
  assign sub_mode = 1'b0;
`endif

  // All outputs are forced low while rst is asserted, so nothing leaks out
  // of a half-finished operation during the reset cycle itself.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.add_a     = 8'h00;
    bus.add_b     = 8'h00;
    bus.add_cin   = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_byte  = 8'h00;
    bus.out_last  = 1'b0;
    bus.out_carry = 1'b0;
    busy          = 1'b0;
    if (!rst) begin
      bus.out_carry = carry;
      case (state)
        ST_LOAD: begin
          bus.in_ready = 1'b1;
        end
        ST_ADD: begin
          busy        = 1'b1;
          bus.add_a   = op_a[byte_idx];
          bus.add_b   = sub_mode ? ~op_b[byte_idx] : op_b[byte_idx];
          // The first byte's carry comes from the latched input (or is
          // forced to 1 for two's-complement subtract); later bytes chain.
          bus.add_cin = (cnt == '0) ? (sub_mode | cin_lat) : carry;
        end
        ST_DRAIN: begin
          busy          = 1'b1;
          bus.out_valid = 1'b1;
          bus.out_byte  = res[byte_idx];
          bus.out_last  = last_byte;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

  // Control state, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
      cnt   <= '0;
      carry <= 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
        res[i] <= 8'h00;
      end
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_fire) begin
            if (cnt == LAST_IN) begin
              state <= ST_ADD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        ST_ADD: begin
          res[byte_idx] <= bus.add_sum;
          carry         <= bus.add_cout;
          if (last_byte) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (last_byte) begin
              state <= ST_LOAD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        default: begin
          state <= ST_LOAD;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Operand capture. No reset is needed here: a reset returns to LOAD, and
  // LOAD refills every entry before the next ADD reads any of them.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (cnt < NB_CW) begin
        op_a[load_idx] <= bus.in_byte;
      end else begin
        op_b[load_idx] <= bus.in_byte;
      end
      if (cnt == '0) begin
        cin_lat <= bus.in_cin;
`ifdef SUBTRACT_EN
        sub_lat <= bus.op_sub;
`endif
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl
//
// Purpose: directed self-checking bench for add_seq_ctrl with NBYTES=4.
// The bench provides the 8-bit adder core as a combinational model on the
// interface.
//
// Optional feature macro: SUBTRACT_EN (enables the subtract vectors).
module tb_add_seq_ctrl;

  localparam int NB = 4;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   errors;

  add_seq_ctrl_if intf ();

  add_seq_ctrl #(.NBYTES(NB)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (intf),
    .busy (busy)
  );

  // External 8-bit adder core.
  assign {intf.add_cout, intf.add_sum} =
    {1'b0, intf.add_a} + {1'b0, intf.add_b} + {8'h00, intf.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams A then B, LSB first. in_cin is only meaningful on A[0], so the
  // later bytes carry the opposite value to show it is not resampled.
  task automatic sendOperands(input logic [31:0] a, input logic [31:0] b,
                              input logic cin, input bit gaps);
    for (int k = 0; k < 2 * NB; k++) begin
      intf.in_valid = 1'b1;
      intf.in_byte  = (k < NB) ? a[8*k +: 8] : b[8*(k-NB) +: 8];
      intf.in_cin   = (k == 0) ? cin : ~cin;
      step();
      if (gaps && k != 2 * NB - 1) begin
        intf.in_valid = 1'b0;
        intf.in_byte  = 8'h5A;
        step();
      end
    end
    intf.in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic cin,
                               input logic sub, input bit gaps,
                               input bit junk);
`ifdef SUBTRACT_EN
    intf.op_sub = sub;
`endif
    sendOperands(a, b, cin, gaps);
    checkOutput({tag, "_add_a0"}, {24'h0, intf.add_a}, {24'h0, a[7:0]});
    checkOutput({tag, "_add_b0"}, {24'h0, intf.add_b},
                {24'h0, sub ? ~b[7:0] : b[7:0]});
    checkOutput({tag, "_add_cin0"}, {31'h0, intf.add_cin},
                {31'h0, sub ? 1'b1 : cin});
    checkOutput({tag, "_busy_add"}, {31'h0, busy}, 32'h1);
    intf.in_valid = junk;
    intf.in_byte  = 8'hA5;
    intf.in_cin   = 1'b1;
    checkOutput({tag, "_in_ready_add"}, {31'h0, intf.in_ready}, 32'h0);
    for (int j = 1; j < NB; j++) begin
      step();
      checkOutput($sformatf("%s_early_valid%0d", tag, j),
                  {31'h0, intf.out_valid}, 32'h0);
    end
    step();
    checkOutput({tag, "_latency_valid"}, {31'h0, intf.out_valid}, 32'h1);
    intf.in_valid = 1'b0;
  endtask

  // Collects the result stream. With toggle set, out_ready alternates each
  // cycle and every stalled cycle re-checks the held byte.
  task automatic collectResult(input string tag, input logic [31:0] exp,
                               input logic exp_carry, input bit toggle);
    int k = 0;
    int guard = 0;
    bit ph = 1'b1;
    while (k < NB && guard < 100) begin
      intf.out_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (intf.out_valid) begin
        checkOutput($sformatf("%s_byte%0d", tag, k),
                    {24'h0, intf.out_byte}, {24'h0, exp[8*k +: 8]});
        checkOutput($sformatf("%s_last%0d", tag, k),
                    {31'h0, intf.out_last}, {31'h0, (k == NB - 1)});
        checkOutput($sformatf("%s_carry%0d", tag, k),
                    {31'h0, intf.out_carry}, {31'h0, exp_carry});
        checkOutput($sformatf("%s_in_ready_drain%0d", tag, k),
                    {31'h0, intf.in_ready}, 32'h0);
        if (intf.out_ready) k++;
      end
      step();
      guard++;
    end
    intf.out_ready = 1'b0;
    checkOutput({tag, "_bytes_seen"}, k, NB);
    checkOutput({tag, "_valid_after"}, {31'h0, intf.out_valid}, 32'h0);
    checkOutput({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
    checkOutput({tag, "_carry_hold"}, {31'h0, intf.out_carry},
                {31'h0, exp_carry});
  endtask

  initial begin
    bit seen;
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    intf.in_valid  = 1'b0;
    intf.in_byte   = 8'h00;
    intf.in_cin    = 1'b0;
    intf.out_ready = 1'b0;
`ifdef SUBTRACT_EN
    intf.op_sub    = 1'b0;
`endif

    $display("[TB] reset checks");
    step();
    step();
    checkOutput("rst_in_ready", {31'h0, intf.in_ready}, 32'h0);
    checkOutput("rst_out_valid", {31'h0, intf.out_valid}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_add_a", {24'h0, intf.add_a}, 32'h0);
    checkOutput("rst_add_cin", {31'h0, intf.add_cin}, 32'h0);
    checkOutput("rst_out_byte", {24'h0, intf.out_byte}, 32'h0);
    checkOutput("rst_out_carry", {31'h0, intf.out_carry}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("rel_in_ready", {31'h0, intf.in_ready}, 32'h1);

    $display("[TB] FF + 01");
    applyStimulus("t1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    collectResult("t1", 32'h00000100, 1'b0, 1'b0);

    $display("[TB] all-ones carry ripple");
    applyStimulus("t2a", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    collectResult("t2a", 32'h00000000, 1'b1, 1'b0);
    applyStimulus("t2b", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    collectResult("t2b", 32'h00000000, 1'b1, 1'b0);

    $display("[TB] back-pressure and ignored input");
    applyStimulus("t3", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b1);
    collectResult("t3", 32'h23456789, 1'b0, 1'b1);

    $display("[TB] reset during ADD");
    sendOperands(32'hAAAA5555, 32'h0F0F0F0F, 1'b1, 1'b0);
    step();
    step();
    checkOutput("t4_add_a_cnt2", {24'h0, intf.add_a}, 32'h000000AA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checkOutput("t4_in_ready", {31'h0, intf.in_ready}, 32'h1);
    checkOutput("t4_busy", {31'h0, busy}, 32'h0);
    checkOutput("t4_out_valid", {31'h0, intf.out_valid}, 32'h0);
    seen = 1'b0;
    for (int j = 0; j < 2 * NB; j++) begin
      step();
      if (intf.out_valid) seen = 1'b1;
    end
    checkOutput("t4_no_spurious_valid", {31'h0, seen}, 32'h0);
    applyStimulus("t4", 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    collectResult("t4", 32'h00000002, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
    $display("[TB] subtract");
    applyStimulus("t5a", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 1'b0);
    collectResult("t5a", 32'hFFFFFFFE, 1'b0, 1'b0);
    applyStimulus("t5b", 32'h00000007, 32'h00000005, 1'b0, 1'b1, 1'b0, 1'b0);
    collectResult("t5b", 32'h00000002, 1'b1, 1'b0);
    applyStimulus("t5c", 32'h00000007, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0);
    collectResult("t5c", 32'h0000000C, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Multi-byte add sequencer that sits around the 8-bit carry-skip adder core, upstream and downstream of it. It collects two NBYTES-wide operands byte-serially over a valid/ready stream, LSB first. It then drives them through the external 8-bit adder one byte per cycle, chaining the carry in a register. The NBYTES-byte result and the final carry are streamed out over a second valid/ready port.

## Interface
Parameters:
- NBYTES, default 4: operand width in bytes; legal range 2..16.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input byte valid
- in_ready  out  1  sequencer accepts input byte
- in_byte  in  8  operand byte; order is A[0..NBYTES-1], then B[0..NBYTES-1], LSB first
- in_cin  in  1  initial carry; sampled with the first byte (A[0]) only
- add_a  out  8  operand A byte to the adder core
- add_b  out  8  operand B byte to the adder core
- add_cin  out  1  carry into the adder core
- add_sum  in  8  adder core sum; combinational from add_a, add_b and add_cin
- add_cout  in  1  adder core carry out
- out_valid  out  1  result byte valid
- out_ready  in  1  downstream accepts result byte
- out_byte  out  8  result byte, LSB first
- out_last  out  1  marks the final (MSB) result byte
- out_carry  out  1  final carry; valid whenever out_valid=1
- busy  out  1  high in ADD and DRAIN

## Operation
- FSM states are LOAD → ADD → DRAIN → LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready handshake writes the byte into the opA/opB register file at index cnt, then increments cnt.
  - On the handshake at cnt=2*NBYTES-1: go to ADD, cnt=0.
- ADD, cnt=i:
  - add_a=opA[i], add_b=opB[i].
  - add_cin = the latched in_cin when i=0, otherwise the carry register.
  - At the clock edge: res[i]<=add_sum and carry<=add_cout.
  - After i=NBYTES-1: go to DRAIN, cnt=0.
- DRAIN:
  - out_valid=1, out_byte=res[cnt], out_carry=carry.
  - out_last=1 when cnt=NBYTES-1.
  - Each handshake increments cnt.
  - The handshake on the last byte returns to LOAD with cnt=0.
- Outside ADD: add_a, add_b and add_cin are driven 0.
- Outside DRAIN: out_valid, out_last and out_byte are 0. out_carry holds its last value.
- No overlap: in_ready=0 in ADD and DRAIN. in_valid in those states is ignored and has no side effects.
- Arithmetic is unsigned modulo 2^(8*NBYTES). out_carry is the carry out of bit 8*NBYTES-1.

## Timing
- Reset values, and values while rst=1:
  - state=LOAD, cnt=0, carry=0, res=0.
  - in_ready=0, add_a=0, add_b=0, add_cin=0.
  - out_valid=0, out_byte=0, out_last=0, out_carry=0, busy=0.
- in_ready is a decode of state gated by !rst. It goes to 1 on the first cycle with rst=0.
- Latency: if the last input handshake happens at edge t, ADD occupies cycles t+1..t+NBYTES. out_valid rises at t+NBYTES+1.
- Throughput: one operation per (2*NBYTES + NBYTES + NBYTES) cycles at minimum, when there is no stall.
- Back-pressure:
  - out_ready=0 holds out_byte, out_last and cnt stable.
  - out_valid never drops before its handshake.
- in_valid=0 gaps in LOAD stall cnt with no other effect.
- Reset mid-operation (LOAD, ADD or DRAIN):
  - Any partial operands or result are discarded.
  - Next cycle: state is LOAD with cnt=0.
  - No spurious out_valid.
- Adder path: add_a, add_b and add_cin come from registers and muxes only. The path to add_sum must close within one clock.

## Configuration
- SUBTRACT_EN defined:
  - Adds input port op_sub (1 bit), sampled with A[0] alongside in_cin.
  - When op_sub=1: add_b is ~opB[i] and the first-byte carry is forced to 1 (in_cin ignored), giving A-B.
  - out_carry=1 means no borrow.
- SUBTRACT_EN undefined: op_sub port is absent and behaviour is addition only.

## Test plan
- NBYTES=4, A=0x000000FF, B=0x00000001, cin=0 → out bytes 00,01,00,00; out_carry=0; out_last on the 4th byte; out_valid rises 5 cycles after the last input handshake.
- A=0xFFFFFFFF, B=0x00000001, cin=0 → 00,00,00,00, out_carry=1. Same A, B=0, cin=1 → same result.
- A=0x12345678, B=0x11111111, out_ready toggled 1/0 every cycle → bytes 89,67,45,23 each held stable while stalled; out_carry=0. in_valid=1 during ADD/DRAIN sees in_ready=0.
- rst=1 for one cycle during ADD (cnt=2) → next cycle in_ready=1, busy=0, out_valid=0. A fresh 0x01+0x01 operation then yields 02,00,00,00.
- SUBTRACT_EN, op_sub=1, A=5, B=7 → FE,FF,FF,FF, out_carry=0. A=7, B=5 → 02,00,00,00, out_carry=1.
